// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: captures operands on start, adds LSB first through one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  sum_sh_q, sum_sh_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          s_bit, c_bit;
  logic [N:0]    sum_cat;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  always_comb begin
    s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_bit   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    // New bit enters at the MSB; slicing the concatenation keeps N=1 legal.
    sum_cat = {s_bit, sum_sh_q};

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          sum_sh_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_cat[N:1];
        carry_d  = c_bit;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = sum_cat[N:1];
          cout_d  = c_bit;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB cell on this final bit.
          ovf_d   = carry_q ^ c_bit;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes arithmetic expectations, monitor checks on done.
module tb_serial_adder;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic [N-1:0] sum;
  logic         cout, busy, done, ovf;

  serial_adder #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  // Reference: plain integer addition, signed range test for overflow.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic ci, input int due);
    exp_t e;
    int total, st;
    total  = int'(x) + int'(y) + int'(ci);
    e.sum  = total[N-1:0];
    e.cout = total[N];
    st     = int'($signed(x)) + int'($signed(y)) + int'(ci);
`ifdef SERIAL_ADDER_OVF_EN
    e.ovf  = (st > (2**(N-1) - 1)) || (st < -(2**(N-1)));
`else
    e.ovf  = 1'b0;
`endif
    e.due  = due;
    return e;
  endfunction

  // Monitor
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("busy_low_at_done", busy, 0);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done=1 sum=%0d, required no done pulse", sum);
        end else begin
          e = sb.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          chk("done_latency_cycle", cyc, e.due);
          last_exp = e;
        end
      end
      prev_done = done && !rst;
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci,
                        input int glitch);
    int busy_cnt;
    bit seen;
    a = x; b = y; cin = ci; start = 1'b1;
    sb.push_back(model(x, y, ci, cyc + N + 1));
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < N + 4 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (i == glitch) begin
          start = 1'b1; a = 1; b = 1; cin = 1'b0;
        end else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", N + 4);
    end
    chk("busy_cycles", busy_cnt, N);
    @(negedge clk);
  endtask

  task automatic check_held();
    repeat (3) @(negedge clk);
    chk("sum_held", sum, last_exp.sum);
    chk("cout_held", cout, last_exp.cout);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd3, 4'd5, 1'b0, -1);
    check_held();
    run_op(4'd15, 4'd1, 1'b0, -1);
    check_held();
    run_op(4'd15, 4'd15, 1'b1, -1);
    check_held();

    // Second start 2 cycles into RUN must be ignored.
    run_op(4'd3, 4'd5, 1'b0, 2);
    check_held();

    // Abandon an operation with an asynchronous reset mid-RUN.
    a = 4'd9; b = 4'd6; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_sum", sum, 0);
    chk("midrun_rst_cout", cout, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);
    run_op(4'd2, 4'd2, 1'b0, -1);

    run_op(4'd7, 4'd1, 1'b0, -1);
    run_op(4'd8, 4'd8, 1'b0, -1);
    run_op(4'd3, 4'd2, 1'b0, -1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run_op(v[3:0], v[7:4], v[8], -1);
    end

    repeat (20) run_op(N'($urandom), N'($urandom), 1'($urandom), -1);

    repeat (N + 3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
